// File: rtl/imem_loader.sv
// imem_loader: UART (8N1) boot loader that packs received bytes little-endian
// into 32-bit words, writes them to instruction memory and releases the core
// once NUM_WORDS words have been written.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits mid-bit, LSB first
// STOP  | sampling the stop bit; on a bad stop bit, wait for the line to go high
module imem_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_WORDS    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_run,
  output logic        done,
  output logic        frame_err
);

  localparam int TW  = $clog2(CLKS_PER_BIT);
  localparam int WCW = $clog2(NUM_WORDS + 1);

  localparam logic [TW-1:0]  T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [7:0]     shift, shift_d;
  logic           err_wait, err_wait_d;
  logic           byte_ok;
  logic           frame_set;

  logic           rx_m, rx_s;
  logic [1:0]     byte_cnt;
  logic [23:0]    word_buf;
  logic [WCW-1:0] word_cnt;

  assign cpu_run = done;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      err_wait <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      err_wait <= err_wait_d;
    end
  end

  // Receiver next-state logic; byte_ok marks the edge that accepts a byte.
  always_comb begin
    state_d    = state;
    timer_d    = timer + TW'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    err_wait_d = err_wait;
    byte_ok    = 1'b0;
    frame_set  = 1'b0;
    case (state)
      IDLE: begin
        timer_d    = '0;
        err_wait_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (timer == T_HALF) begin
          timer_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (timer == T_FULL) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (err_wait) begin
          // Hold here so the low stop bit is never mistaken for a new start.
          timer_d = '0;
          if (rx_s) begin
            state_d    = IDLE;
            err_wait_d = 1'b0;
          end
        end else if (timer == T_FULL) begin
          timer_d = '0;
          if (rx_s) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            frame_set  = 1'b1;
            err_wait_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Once the program is loaded the line is ignored entirely.
    if (done) begin
      state_d    = IDLE;
      timer_d    = '0;
      err_wait_d = 1'b0;
      byte_ok    = 1'b0;
      frame_set  = 1'b0;
    end
  end

  // Word packer and memory write port; wr_addr/wr_data only change on a
  // completed word so they stay stable until the next write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= '0;
      word_buf  <= '0;
      word_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en <= byte_ok && (byte_cnt == 2'd3);
      if (frame_set) frame_err <= 1'b1;
      if (byte_ok) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= shift;
          2'd1: word_buf[15:8]  <= shift;
          2'd2: word_buf[23:16] <= shift;
          default: begin
            wr_data <= {shift, word_buf};
            wr_addr <= 32'(word_cnt) << 2;
          end
        endcase
      end
      if (wr_en) begin
        word_cnt <= word_cnt + WCW'(1);
        if (word_cnt == W_LAST) done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that fills the core's instruction memory before execution starts. It receives 8N1 UART bytes on a single serial line and packs them little-endian into 32-bit words. It issues one write strobe per word to the instruction-memory write port and releases the core once a fixed program length has been loaded. It is the writer side of the instruction memory, which the core itself only reads.

## Interface
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be even and ≥ 4.
- NUM_WORDS, 64, program length in 32-bit words; must be ≥ 1.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- rx  input  1  UART serial line, idle high, asynchronous to clk.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  32  byte address of the word being written: word index × 4.
- wr_data  output  32  assembled instruction word.
- cpu_run  output  1  high once loading is complete; gates the core's reset/PC.
- done  output  1  same as cpu_run; separate port for status/LED.
- frame_err  output  1  sticky; set on any bad stop bit, cleared only by rst.

## Operation
- rx passes through a 2-flop synchronizer, rx_s; all decisions use rx_s.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: on rx_s == 0, go to START and clear the bit timer.
  - START: at timer == CLKS_PER_BIT/2 − 1, sample rx_s. If 1, treat as a false start and return to IDLE. If 0, go to DATA and clear the timer.
  - DATA: sample rx_s each time the timer reaches CLKS_PER_BIT − 1, so samples land mid-bit. Shift bits in LSB first. After the 8th sample, go to STOP.
  - STOP: sample at timer == CLKS_PER_BIT − 1.
    - If rx_s == 1, the byte is valid; return to IDLE.
    - If rx_s == 0, set frame_err, discard the byte and leave byte_cnt unchanged. Wait in STOP until rx_s == 1, then return to IDLE.
- Packer:
  - byte_cnt runs 0..3. A valid byte k is placed in wr_data[8k+7:8k].
  - On the valid 4th byte, byte_cnt wraps to 0 and wr_en pulses.
  - word_cnt then increments; its width is $clog2(NUM_WORDS+1).
- After word NUM_WORDS−1 is written, done and cpu_run go high and stay high.
  - All further rx traffic is ignored: no wr_en, and frame_err is not updated.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, done 0, cpu_run 0, frame_err 0. FSM returns to IDLE; byte_cnt and word_cnt are 0.
- Reset mid-frame or mid-word discards the partial byte and the partial word. Loading restarts at address 0.

## Timing
- Synchronizer latency: 2 clk cycles from an rx edge to rx_s.
- Valid-byte event: the cycle after the STOP sample edge.
- wr_en for a word: high for exactly 1 cycle, on the cycle after that word's 4th valid STOP sample.
  - wr_addr and wr_data are stable during the wr_en cycle.
  - They hold their values until the next write.
- wr_addr equals the old word_cnt × 4 during the strobe. word_cnt increments at the same clock edge that ends the strobe.
- done/cpu_run rise on the cycle after the final wr_en, and never fall except on rst.
- Minimum byte spacing: 10 × CLKS_PER_BIT cycles; back-to-back frames with no idle gap are accepted.
- The shortest possible load is 40 × CLKS_PER_BIT × NUM_WORDS cycles plus a small fixed overhead.
- A start edge arriving in the same cycle as the STOP→IDLE transition is detected on the next cycle. No byte is lost as long as the frame is in spec.

## Test plan
- Reset check: hold rst low, toggle rx → all outputs 0. Release → still 0 with rx idle high for 1000 cycles.
- Single word: send 0x13, 0x05, 0x50, 0x00 (CLKS_PER_BIT=16) → exactly one wr_en pulse, wr_addr=0x00000000, wr_data=0x00500513.
- Full load, NUM_WORDS=4: send 16 bytes for 0x00500513, 0x00A00593, 0x00B50633, 0x0000006F.
  - Expect wr_en at addresses 0x0, 0x4, 0x8, 0xC with those data values.
  - done and cpu_run go high the cycle after the 4th strobe.
  - Extra bytes sent afterwards produce no strobe.
- Framing error: send byte 0x13 with stop bit 0, then a valid 4-byte word 0xDEADBEEF → frame_err=1 and stays 1. The first strobe carries 0xDEADBEEF at address 0.
- False start: a 3-cycle low glitch on rx → no byte received, FSM back in IDLE, no frame_err.
- Reset mid-load: after 6 valid bytes, pulse rst low. Then send 4 bytes of 0x11223344 → strobe at wr_addr=0 with wr_data=0x11223344, and done=0.
